demux_1x8_32bit_buf: RTL and testbench
======================================

Name: demux_1x8_32bit_buf

Overview:
- Registered 1-to-8 distributor: the write-side counterpart of the 8-to-1 32-bit read select path.
- Takes one 32-bit word plus a 3-bit destination select under a valid/ready handshake.
- Steers the word into one of eight single-entry holding slots. Each slot drains through its own valid/ready port.
- Sits between the datapath result bus and up to eight consumers (register banks, writeback queues, peripherals).

Parameters:
- DATA_W, 32, width of every data path. Bit-for-bit routing; no data transformation.

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_W  word to route
- in_sel  input  3  destination slot index 0..7
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  distributor accepts this cycle
- out0..out7  output  DATA_W each  slot i held word
- out_valid  output  8  bit i: slot i holds an undelivered word
- out_ready  input  8  bit i: consumer i takes slot i this cycle
- occupancy  output  4  number of full slots, 0..8

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - out0..out7 = 0
  - out_valid = 8'h00
  - occupancy = 0
  - Any transfer in flight is discarded.
  - After release, the first accept occurs on the first rising edge with rst_n high.
- in_ready (combinational, no dependence on in_valid): in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - Ready depends only on the selected slot; the other seven slots never stall the input.
- Accept: in_valid & in_ready at a rising edge.
  - Slot in_sel loads in_data on that edge.
  - out_valid[in_sel] = 1 from the next cycle. Latency: 1 cycle input to output.
- Drain: out_valid[i] & out_ready[i] at an edge. out_valid[i] clears on that edge unless slot i is reloaded on the same edge.
- Same-cycle drain and reload of the same slot: the old word is delivered, the new word is loaded, and out_valid[i] stays 1. This gives full throughput to one slot.
- Drain of slot j concurrent with accept into slot i≠j: both take effect independently.
- Stall: while out_valid[i] & !out_ready[i], outi is held bit-stable.
- Empty slots: outi keeps its last value (0 after reset). Consumers must qualify with out_valid[i].
- out_ready[i] asserted while out_valid[i]=0: ignored, no state change.
- in_valid low: in_sel and in_data are don't-care and cause no state change. in_ready may still be high.
- Data and select must be held stable while in_valid & !in_ready. The block does not latch a pending request.
- occupancy: registered. Next value = popcount of next out_valid. Always equals popcount(out_valid). 8 means every slot full.
- No overflow is possible by construction. A write to a full slot is back-pressured, never dropped or overwritten.
- Sequential logic: plain DATA_W registers with per-slot load enable, derived from a 3-to-8 decode of in_sel gated by accept.

Test Plan:
- Reset/basic route:
  - Stimulus: assert rst_n=0 mid-cycle, release, then in_data=32'hDEADBEEF, in_sel=5, in_valid=1, out_ready=0.
  - Required: outputs 0 asynchronously during reset; out5=32'hDEADBEEF, out_valid=8'h20, occupancy=1 one cycle later; all other outi=0.
- Back-pressure:
  - Stimulus: with slot 5 full and out_ready[5]=0, present in_sel=5, data 32'h1.
  - Required: in_ready=0 and out5 stays 32'hDEADBEEF. Switching in_sel to 2 gives in_ready=1; after accept out_valid=8'h24, occupancy=2.
- Same-slot throughput:
  - Stimulus: out_ready[3]=1 held, in_sel=3, in_valid=1, data 1,2,3,4 on consecutive cycles.
  - Required: in_ready stays 1; out3 shows 1,2,3,4 on consecutive cycles with out_valid[3]=1 throughout; occupancy constant.
- Fill all:
  - Stimulus: out_ready=0, write sel 0..7 with data 32'h100+i.
  - Required: occupancy=8, out_valid=8'hFF, outi=32'h100+i; any further in_sel gives in_ready=0.
- Concurrent drain/accept:
  - Stimulus: from full, out_ready=8'h81 while writing sel 0 with 32'hA5A5A5A5.
  - Required: slot 0 reloads with 32'hA5A5A5A5 and out_valid[0] stays 1; slot 7 clears; occupancy=7.
- Reset mid-operation:
  - Stimulus: from full with in_valid=1, pulse rst_n low for less than one clock.
  - Required: all outputs 0 immediately; no accept on the reset edge; normal accepts resume after release.

Source files
------------

// File: rtl/demux_1x8_32bit_buf.sv
// demux_1x8_32bit_buf: registered 1-to-8 word distributor; each of eight
// single-entry slots is loaded by select under valid/ready and drains on its own handshake.
module demux_1x8_32bit_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic [3:0]        occupancy
);
  logic [DATA_W-1:0] slot_q [8];
  logic [7:0] valid_q, valid_d, load;
  logic [3:0] occ_q, occ_d;
  // a full slot accepts again only when it is drained on the same edge
  assign in_ready = !valid_q[in_sel] || out_ready[in_sel];
  assign load = (in_valid && in_ready) ? 8'b1 << in_sel : 8'h00;
  always_comb begin
    valid_d = (valid_q & ~out_ready) | load;
    occ_d = '0;
    for (int i = 0; i < 8; i++) occ_d = occ_d + 4'(valid_d[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < 8; i++) slot_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q <= occ_d;
      for (int i = 0; i < 8; i++) if (load[i]) slot_q[i] <= in_data;
    end
  end
  assign out0 = slot_q[0];
  assign out1 = slot_q[1];
  assign out2 = slot_q[2];
  assign out3 = slot_q[3];
  assign out4 = slot_q[4];
  assign out5 = slot_q[5];
  assign out6 = slot_q[6];
  assign out7 = slot_q[7];
  assign out_valid = valid_q;
  assign occupancy = occ_q;
endmodule

// File: tb/tb_demux_1x8_32bit_buf.sv
// tb_demux_1x8_32bit_buf: constant vector table for the directed scenarios plus
// randomized traffic checked against a per-slot word/full model.
module tb_demux_1x8_32bit_buf;
  logic        clk, rst_n;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid, in_ready;
  logic [31:0] dout [8];
  logic [7:0]  out_valid, out_ready;
  logic [3:0]  occupancy;
  int checks, errors;

  demux_1x8_32bit_buf #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0(dout[0]), .out1(dout[1]), .out2(dout[2]), .out3(dout[3]),
    .out4(dout[4]), .out5(dout[5]), .out6(dout[6]), .out7(dout[7]),
    .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  logic [31:0] m_word [8];
  bit          m_full [8];

  typedef struct {
    logic [31:0] d;
    logic [2:0]  s;
    logic        v;
    logic [7:0]  r;
    logic        er;
    logic [7:0]  ev;
    logic [3:0]  eo;
    logic [31:0] ew;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_word[i] = 0;
      m_full[i] = 0;
    end
  endtask

  task automatic check_model();
    logic [7:0] v;
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      v[i] = m_full[i];
      n += int'(m_full[i]);
      chk($sformatf("model_out%0d", i), dout[i], m_word[i]);
    end
    chk("model_out_valid", {24'h0, out_valid}, {24'h0, v});
    chk("model_occupancy", {28'h0, occupancy}, n);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_out%0d", tag, i), dout[i], 0);
    chk({tag, "_out_valid"}, {24'h0, out_valid}, 0);
    chk({tag, "_occupancy"}, {28'h0, occupancy}, 0);
  endtask

  // one clock of traffic: checks in_ready mid-cycle, then all outputs after the edge
  task automatic cycle(input logic [31:0] d, input logic [2:0] s, input logic v,
                       input logic [7:0] r, output logic rdy);
    bit exp_rdy;
    in_data = d; in_sel = s; in_valid = v; out_ready = r;
    #1;
    exp_rdy = !m_full[s] || r[s];
    rdy = in_ready;
    chk("model_in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    @(posedge clk);
    for (int i = 0; i < 8; i++) if (r[i]) m_full[i] = 0;
    if (v && exp_rdy) begin
      m_word[s] = d;
      m_full[s] = 1;
    end
    #1;
    check_model();
  endtask

  initial begin
    logic rdy;
    checks = 0; errors = 0;
    rst_n = 1; in_data = 0; in_sel = 0; in_valid = 0; out_ready = 0;
    model_reset();
    #3 rst_n = 0;
    #1 check_zero("reset_async");
    #8 rst_n = 1;
    #1;

    tbl.push_back('{32'hDEADBEEF, 3'd5, 1'b1, 8'h00, 1'b1, 8'h20, 4'd1, 32'hDEADBEEF});
    tbl.push_back('{32'h00000001, 3'd5, 1'b1, 8'h00, 1'b0, 8'h20, 4'd1, 32'hDEADBEEF});
    tbl.push_back('{32'h00000001, 3'd2, 1'b1, 8'h00, 1'b1, 8'h24, 4'd2, 32'h00000001});
    for (int k = 1; k <= 4; k++)
      tbl.push_back('{32'(k), 3'd3, 1'b1, 8'h08, 1'b1, 8'h2C, 4'd3, 32'(k)});
    tbl.push_back('{32'h0, 3'd5, 1'b0, 8'hFF, 1'b1, 8'h00, 4'd0, 32'hDEADBEEF});
    for (int k = 0; k < 8; k++)
      tbl.push_back('{32'h100 + 32'(k), 3'(k), 1'b1, 8'h00, 1'b1,
                      8'((16'h1 << (k + 1)) - 1), 4'(k + 1), 32'h100 + 32'(k)});
    tbl.push_back('{32'h55, 3'd4, 1'b1, 8'h00, 1'b0, 8'hFF, 4'd8, 32'h104});
    tbl.push_back('{32'hA5A5A5A5, 3'd0, 1'b1, 8'h81, 1'b1, 8'h7F, 4'd7, 32'hA5A5A5A5});
    tbl.push_back('{32'h0, 3'd7, 1'b0, 8'h80, 1'b1, 8'h7F, 4'd7, 32'h107});

    foreach (tbl[k]) begin
      cycle(tbl[k].d, tbl[k].s, tbl[k].v, tbl[k].r, rdy);
      chk($sformatf("vec%0d_in_ready", k), {31'h0, rdy}, {31'h0, tbl[k].er});
      chk($sformatf("vec%0d_out_valid", k), {24'h0, out_valid}, {24'h0, tbl[k].ev});
      chk($sformatf("vec%0d_occupancy", k), {28'h0, occupancy}, {28'h0, tbl[k].eo});
      chk($sformatf("vec%0d_word", k), dout[tbl[k].s], tbl[k].ew);
    end

    cycle(32'h200, 3'd7, 1'b1, 8'h00, rdy);
    chk("refill_full", {28'h0, occupancy}, 8);
    in_data = 32'h77; in_sel = 0; in_valid = 1; out_ready = 8'h01;
    #6 rst_n = 0;
    #1 check_zero("reset_midop");
    #4 rst_n = 1;
    #1 check_zero("reset_edge_no_accept");
    model_reset();
    cycle(32'h77, 3'd0, 1'b1, 8'h01, rdy);
    chk("post_reset_out0", dout[0], 32'h77);
    chk("post_reset_valid", {24'h0, out_valid}, 32'h01);

    for (int k = 0; k < 400; k++)
      cycle($urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            8'($urandom), rdy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
